regfile_fwd: RTL and testbench



---
 rtl/regfile_fwd_pkg.sv | 13 +
 rtl/regfile_fwd_core.sv | 31 +++
 rtl/regfile_fwd.sv | 62 ++++++
 tb/tb_regfile_fwd.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/regfile_fwd_pkg.sv
// regfile_fwd_pkg: shared widths and forward-source selection for the forwarding register file.
package regfile_fwd_pkg;
    localparam int RF_DATA_W  = 32;
    localparam int RF_ADDR_W  = 5;
    localparam int RF_REG_NUM = 32;

    typedef enum logic [1:0] {SRC_REG, SRC_WB, SRC_MEM, SRC_EX} fwd_src_e;

    // Youngest in-flight producer wins: EX, then MEM, then the same-cycle WB write.
    function automatic fwd_src_e fwd_pick(logic ex_hit, logic mem_hit, logic wb_hit);
        return ex_hit ? SRC_EX : mem_hit ? SRC_MEM : wb_hit ? SRC_WB : SRC_REG;
    endfunction
endpackage

// File: rtl/regfile_fwd_core.sv
// regfile_fwd_core: REG_NUM x DATA_W array, async reset, one write port, two raw read ports.
module regfile_fwd_core
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int REG_NUM = RF_REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] regs_q [REG_NUM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
        end else if (we && waddr != '0) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];
endmodule

// File: rtl/regfile_fwd.sv
// regfile_fwd: register file with EX/MEM/WB operand forwarding and load-use stall request.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int REG_NUM = RF_REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              re1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              stallreq
);
    logic [1:0]        re;
    logic [ADDR_W-1:0] ra  [2];
    logic [DATA_W-1:0] raw [2];
    logic [DATA_W-1:0] rd  [2];

    regfile_fwd_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) u_core (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (raw[0]),
        .rdata2 (raw[1])
    );

    assign re    = {re2, re1};
    assign ra[0] = raddr1;
    assign ra[1] = raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_port
        fwd_src_e src;
        logic     zero;
        assign zero  = rst || !re[p] || ra[p] == '0;
        assign src   = fwd_pick(ex_wreg && ex_wd == ra[p], mem_wreg && mem_wd == ra[p], we && waddr == ra[p]);
        assign rd[p] = zero ? '0 : src == SRC_EX ? ex_wdata : src == SRC_MEM ? mem_wdata : src == SRC_WB ? wdata : raw[p];
    end

    assign rdata1   = rd[0];
    assign rdata2   = rd[1];
    assign stallreq = !rst && ex_is_load && ex_wreg && ex_wd != '0 &&
                      ((re1 && raddr1 == ex_wd) || (re2 && raddr2 == ex_wd));
endmodule

// File: tb/tb_regfile_fwd.sv
// tb_regfile_fwd: directed and random checks of regfile_fwd against an array-plus-priority model.
module tb_regfile_fwd;
    logic        clk = 1'b0;
    logic        rst;
    logic        we, ex_wreg, ex_is_load, mem_wreg, re1, re2;
    logic [4:0]  waddr, ex_wd, mem_wd, raddr1, raddr2;
    logic [31:0] wdata, ex_wdata, mem_wdata;
    logic [31:0] rdata1, rdata2;
    logic        stallreq;

    int errors = 0;
    int checks = 0;
    bit [31:0] mreg [32];

    regfile_fwd dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .ex_wreg    (ex_wreg),
        .ex_wd      (ex_wd),
        .ex_wdata   (ex_wdata),
        .ex_is_load (ex_is_load),
        .mem_wreg   (mem_wreg),
        .mem_wd     (mem_wd),
        .mem_wdata  (mem_wdata),
        .re1        (re1),
        .re2        (re2),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .stallreq   (stallreq)
    );

    always #5 clk = ~clk;

    // Architectural state: cleared by reset, written only by WB on a clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mreg[i] = 0;
        end else if (we && waddr != 0) begin
            mreg[waddr] = wdata;
        end
    end

    function automatic logic [31:0] exp_rd(logic r, logic [4:0] a);
        if (rst || !r || a == 0) return 0;
        if (ex_wreg && ex_wd == a) return ex_wdata;
        if (mem_wreg && mem_wd == a) return mem_wdata;
        if (we && waddr == a) return wdata;
        return mreg[a];
    endfunction

    function automatic logic exp_stall();
        if (rst || !ex_is_load || !ex_wreg || ex_wd == 0) return 0;
        return (re1 && raddr1 == ex_wd) || (re2 && raddr2 == ex_wd);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model rdata1", rdata1, exp_rd(re1, raddr1));
        chk("model rdata2", rdata2, exp_rd(re2, raddr2));
        chk("model stallreq", {31'b0, stallreq}, {31'b0, exp_stall()});
    end

    task automatic idle();
        we = 0; waddr = 0; wdata = 0;
        ex_wreg = 0; ex_wd = 0; ex_wdata = 0; ex_is_load = 0;
        mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
        re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        idle();
        re1 = 1; raddr1 = 5; ex_wreg = 1; ex_wd = 5; ex_wdata = 32'h1111_1111;
        mid();
        chk("reset rdata1", rdata1, 32'h0);
        rst = 0;
        idle();
        // write/read
        cyc(); we = 1; waddr = 3; wdata = 32'h1234_5678;
        cyc(); idle(); re1 = 1; raddr1 = 3;
        mid(); chk("write-read $3", rdata1, 32'h1234_5678);
        // reset mid-run
        cyc(); idle(); we = 1; waddr = 5; wdata = 32'hDEAD_BEEF;
        cyc(); idle(); re1 = 1; raddr1 = 5;
        mid(); chk("pre-reset $5", rdata1, 32'hDEAD_BEEF);
        rst = 1;
        #1 chk("async reset $5", rdata1, 32'h0);
        mid(); rst = 0;
        #1 chk("post-reset $5", rdata1, 32'h0);
        // $0 guard
        cyc(); idle(); we = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
        ex_wreg = 1; ex_wd = 0; ex_wdata = 32'h5555_5555;
        mem_wreg = 1; mem_wd = 0; mem_wdata = 32'h6666_6666;
        re1 = 1; raddr1 = 0; re2 = 1; raddr2 = 0;
        mid(); chk("$0 port1", rdata1, 32'h0);
        chk("$0 port2", rdata2, 32'h0);
        cyc(); we = 0;
        mid(); chk("$0 after write", rdata1, 32'h0);
        // priority EX > MEM > WB
        cyc(); idle(); re1 = 1; re2 = 1; raddr1 = 7; raddr2 = 7;
        ex_wreg = 1; ex_wd = 7; ex_wdata = 32'hAAAA_0000;
        mem_wreg = 1; mem_wd = 7; mem_wdata = 32'hBBBB_0000;
        we = 1; waddr = 7; wdata = 32'hCCCC_0000;
        #1 chk("prio ex p1", rdata1, 32'hAAAA_0000);
        chk("prio ex p2", rdata2, 32'hAAAA_0000);
        ex_wreg = 0;
        #1 chk("prio mem p1", rdata1, 32'hBBBB_0000);
        chk("prio mem p2", rdata2, 32'hBBBB_0000);
        mem_wreg = 0;
        #1 chk("prio wb p1", rdata1, 32'hCCCC_0000);
        chk("prio wb p2", rdata2, 32'hCCCC_0000);
        cyc(); we = 0;
        mid(); chk("wb committed $7", rdata2, 32'hCCCC_0000);
        // load-use
        cyc(); idle(); ex_is_load = 1; ex_wreg = 1; ex_wd = 9; ex_wdata = 32'h0BAD_0BAD;
        re2 = 1; raddr2 = 9;
        mid(); chk("stall re2", {31'b0, stallreq}, 32'h1);
        re2 = 0;
        #1 chk("stall re2 off", {31'b0, stallreq}, 32'h0);
        re1 = 1; raddr1 = 9;
        #1 chk("stall re1", {31'b0, stallreq}, 32'h1);
        ex_is_load = 0;
        #1 chk("stall not load", {31'b0, stallreq}, 32'h0);
        ex_is_load = 1; ex_wd = 0; raddr1 = 0;
        #1 chk("stall wd 0", {31'b0, stallreq}, 32'h0);
        // random
        for (int n = 0; n < 10000; n++) begin
            cyc();
            rst        = ($urandom_range(0, 199) == 0);
            we         = 1'($urandom_range(0, 1));
            waddr      = 5'($urandom_range(0, 7));
            wdata      = $urandom;
            ex_wreg    = 1'($urandom_range(0, 1));
            ex_wd      = 5'($urandom_range(0, 7));
            ex_wdata   = $urandom;
            ex_is_load = 1'($urandom_range(0, 1));
            mem_wreg   = 1'($urandom_range(0, 1));
            mem_wd     = 5'($urandom_range(0, 7));
            mem_wdata  = $urandom;
            re1        = ($urandom_range(0, 3) != 0);
            re2        = ($urandom_range(0, 3) != 0);
            raddr1     = 5'($urandom_range(0, 7));
            raddr2     = 5'($urandom_range(0, 7));
        end
        cyc(); rst = 0; idle();
        mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
